mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory access unit sitting between the execute stage and a simple
// request/ready bus. It accepts a load or store, checks alignment, drives a
// single bus transaction from registers, and returns right-justified load
// data or a fault code.
//
// Ports
//   clock_In, reset_In         : rising-edge clock, async active-high reset
//   memAccess_In               : request, held high until writeback
//   memAddr_In / memData_In    : byte address / right-justified store data
//   memDataWidth_In            : NONE / BYTE / HALF / WORD
//   memIsRead_In               : 1 = load, 0 = store
//   memAccessOK_Out            : access complete, result valid
//   memData_Out                : load data, zero above the access width
//   memException_Out           : exception code (NONE when no fault)
//   busRequest_Out .. busWriteData_Out : registered bus request side
//   busReady_In, busError_In, busReadData_In : bus response side

`ifndef MEM_WIDTH_NONE
`define MEM_WIDTH_NONE 2'd0
`define MEM_WIDTH_BYTE 2'd1
`define MEM_WIDTH_HALF 2'd2
`define MEM_WIDTH_WORD 2'd3
`endif

`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_NONE             4'd0
`define EXCEP_MISALIGNED_LOAD  4'd4
`define EXCEP_LOAD_FAULT       4'd5
`define EXCEP_MISALIGNED_STORE 4'd6
`define EXCEP_STORE_FAULT      4'd7
`endif

module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clock_In,
  input  logic                      reset_In,
  input  logic                      memAccess_In,
  input  logic [31:0]               memAddr_In,
  input  logic [31:0]               memData_In,
  input  logic [1:0]                memDataWidth_In,
  input  logic                      memIsRead_In,
  output logic                      memAccessOK_Out,
  output logic [31:0]               memData_Out,
  output logic [`EXCEPTION_LEN-1:0] memException_Out,
  output logic                      busRequest_Out,
  output logic [31:0]               busAddr_Out,
  output logic                      busWrite_Out,
  output logic [3:0]                busByteEnable_Out,
  output logic [31:0]               busWriteData_Out,
  input  logic                      busReady_In,
  input  logic                      busError_In,
  input  logic [31:0]               busReadData_In
);

  // DRAIN is a BUS cycle whose result will be thrown away because the
  // requester has already withdrawn.
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_t;

  state_t state;
  state_t state_next;

  logic [31:0]               wait_cnt;
  logic [1:0]                width_q;
  logic [1:0]                lane_q;
  logic                      is_read_q;
  logic [31:0]               result_data;
  logic [`EXCEPTION_LEN-1:0] result_exc;

  logic        misaligned;
  logic        needs_bus;
  logic        in_bus;
  logic        timeout_hit;
  logic        bus_done;
  logic        bus_fault;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;

  // Request decode: alignment, byte lanes and store-data lane placement.
  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = 32'd0;
    case (memDataWidth_In)
      `MEM_WIDTH_BYTE: begin
        be_calc    = 4'b0001 << memAddr_In[1:0];
        wdata_calc = {24'd0, memData_In[7:0]} << {memAddr_In[1:0], 3'b000};
      end
      `MEM_WIDTH_HALF: begin
        misaligned = memAddr_In[0];
        be_calc    = 4'b0011 << memAddr_In[1:0];
        wdata_calc = {16'd0, memData_In[15:0]} << {memAddr_In[1], 4'b0000};
      end
      `MEM_WIDTH_WORD: begin
        misaligned = (memAddr_In[1:0] != 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = memData_In;
      end
      default: begin
        misaligned = 1'b0;
      end
    endcase
    needs_bus = !misaligned && (memDataWidth_In != `MEM_WIDTH_NONE);
  end

  // Bus response decode; an error outranks a simultaneous ready, and a
  // timeout is only a fault when ready did not arrive in that cycle.
  always_comb begin
    in_bus      = (state == BUS) || (state == DRAIN);
    timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (wait_cnt == (TIMEOUT_CYCLES - 32'd1));
    bus_done    = in_bus && (busReady_In || busError_In || timeout_hit);
    bus_fault   = busError_In || !busReady_In;
    rd_shifted  = busReadData_In >> {lane_q, 3'b000};
    case (width_q)
      `MEM_WIDTH_BYTE: load_data = {24'd0, rd_shifted[7:0]};
      `MEM_WIDTH_HALF: load_data = {16'd0, rd_shifted[15:0]};
      `MEM_WIDTH_WORD: load_data = rd_shifted;
      default:         load_data = 32'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (memAccess_In) state_next = needs_bus ? BUS : DONE;
        else              state_next = IDLE;
      end
      BUS: begin
        if (bus_done)           state_next = memAccess_In ? DONE : IDLE;
        else if (!memAccess_In) state_next = DRAIN;
        else                    state_next = BUS;
      end
      DRAIN: begin
        if (bus_done) state_next = IDLE;
        else          state_next = DRAIN;
      end
      DONE: begin
        if (memAccess_In) state_next = DONE;
        else              state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_In or posedge reset_In) begin
    if (reset_In) state <= IDLE;
    else          state <= state_next;
  end

  // Request capture, registered bus outputs, wait counter and result latch.
  always_ff @(posedge clock_In or posedge reset_In) begin
    if (reset_In) begin
      wait_cnt          <= 32'd0;
      width_q           <= `MEM_WIDTH_NONE;
      lane_q            <= 2'd0;
      is_read_q         <= 1'b0;
      result_data       <= 32'd0;
      result_exc        <= `EXCEP_NONE;
      busRequest_Out    <= 1'b0;
      busAddr_Out       <= 32'd0;
      busWrite_Out      <= 1'b0;
      busByteEnable_Out <= 4'd0;
      busWriteData_Out  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (memAccess_In) begin
            wait_cnt    <= 32'd0;
            width_q     <= memDataWidth_In;
            lane_q      <= memAddr_In[1:0];
            is_read_q   <= memIsRead_In;
            result_data <= 32'd0;
            if (misaligned) result_exc <= memIsRead_In ? `EXCEP_MISALIGNED_LOAD : `EXCEP_MISALIGNED_STORE;
            else            result_exc <= `EXCEP_NONE;
            if (needs_bus) begin
              busRequest_Out    <= 1'b1;
              busAddr_Out       <= {memAddr_In[31:2], 2'b00};
              busWrite_Out      <= !memIsRead_In;
              busByteEnable_Out <= be_calc;
              busWriteData_Out  <= memIsRead_In ? 32'd0 : wdata_calc;
            end else begin
              busRequest_Out <= 1'b0;
            end
          end else begin
            wait_cnt <= 32'd0;
          end
        end
        BUS, DRAIN: begin
          if (bus_done) begin
            busRequest_Out    <= 1'b0;
            busAddr_Out       <= 32'd0;
            busWrite_Out      <= 1'b0;
            busByteEnable_Out <= 4'd0;
            busWriteData_Out  <= 32'd0;
            if (bus_fault) begin
              result_data <= 32'd0;
              result_exc  <= is_read_q ? `EXCEP_LOAD_FAULT : `EXCEP_STORE_FAULT;
            end else begin
              result_data <= is_read_q ? load_data : 32'd0;
              result_exc  <= `EXCEP_NONE;
            end
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        default: begin
          wait_cnt <= wait_cnt;
        end
      endcase
    end
  end

  // The acknowledge follows memAccess_In so a withdrawn request never sees it.
  assign memAccessOK_Out  = (state == DONE) && memAccess_In;
  assign memData_Out      = (state == DONE) ? result_data : 32'd0;
  assign memException_Out = (state == DONE) ? result_exc : `EXCEP_NONE;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (built with TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  localparam logic [1:0] W_NONE = 2'd0, W_BYTE = 2'd1, W_HALF = 2'd2, W_WORD = 2'd3;
  localparam logic [3:0] X_NONE = 4'd0, X_MIS_LD = 4'd4, X_LD_FLT = 4'd5,
                         X_MIS_ST = 4'd6, X_ST_FLT = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_access = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_data = 32'd0;
  logic [1:0]  mem_width = 2'd0;
  logic        mem_is_read = 1'b0;
  logic        ok;
  logic [31:0] rdata_out;
  logic [3:0]  exc;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic        bus_error = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] w; logic [31:0] a; logic [31:0] d; logic rd; int dly; logic err; logic [31:0] rdata;
    logic e_req; logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata;
    logic [31:0] e_data; logic [3:0] e_exc; int e_lat; int e_rc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock_In(clk), .reset_In(rst),
    .memAccess_In(mem_access), .memAddr_In(mem_addr), .memData_In(mem_data),
    .memDataWidth_In(mem_width), .memIsRead_In(mem_is_read),
    .memAccessOK_Out(ok), .memData_Out(rdata_out), .memException_Out(exc),
    .busRequest_Out(bus_req), .busAddr_Out(bus_addr), .busWrite_Out(bus_write),
    .busByteEnable_Out(bus_be), .busWriteData_Out(bus_wdata),
    .busReady_In(bus_ready), .busError_In(bus_error), .busReadData_In(bus_rdata)
  );

  // Drives one access and a bus responder (dly < 0: never ready); reports what the DUT did.
  task automatic run_access(input vec_t v, output logic ok_seen, output int lat,
                            output logic [31:0] o_data, output logic [3:0] o_exc,
                            output int rc, output logic [31:0] o_addr, output logic [3:0] o_be,
                            output logic [31:0] o_wdata, output logic o_write, output logic ok_after);
    mem_access = 1'b1; mem_addr = v.a; mem_data = v.d; mem_width = v.w; mem_is_read = v.rd;
    bus_ready = 1'b0; bus_error = 1'b0;
    ok_seen = 1'b0; lat = 0; o_data = 32'd0; o_exc = 4'd0; rc = 0;
    o_addr = 32'd0; o_be = 4'd0; o_wdata = 32'd0; o_write = 1'b0; ok_after = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        rc++;
        o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata; o_write = bus_write;
        if (v.dly >= 0 && c >= v.dly + 1) begin
          bus_ready = 1'b1; bus_error = v.err; bus_rdata = v.rdata;
        end else begin
          bus_ready = 1'b0; bus_error = 1'b0; bus_rdata = 32'hDEAD_0000;
        end
      end else begin
        bus_ready = 1'b0; bus_error = 1'b0;
      end
      #1;
      if (ok) begin
        ok_seen = 1'b1; lat = c; o_data = rdata_out; o_exc = exc;
        break;
      end
    end
    mem_access = 1'b0;
    #1;
    ok_after = ok;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ok !== 1'b0)       begin errors++; $display("FAIL reset_ok: got %0b want 0", ok); end
    checks++; if (bus_req !== 1'b0)  begin errors++; $display("FAIL reset_req: got %0b want 0", bus_req); end
    checks++; if (rdata_out !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", rdata_out); end
    checks++; if (exc !== X_NONE)    begin errors++; $display("FAIL reset_exc: got %0d want 0", exc); end
    checks++; if ({bus_addr, bus_be, bus_wdata, bus_write} !== 69'd0)
      begin errors++; $display("FAIL reset_bus: got %h/%b/%h/%b want zeros", bus_addr, bus_be, bus_wdata, bus_write); end
    rst = 1'b0;
  endtask

  task automatic test_table_accesses();
    logic ok_seen, ok_after, o_write;
    int lat, rc;
    logic [31:0] o_data, o_addr, o_wdata;
    logic [3:0] o_exc, o_be;
    vec_t e;
    tbl.delete();
    //             w      addr          data          rd   dly err rdata          req  eaddr         ebe      ewdata        edata         eexc      lat rc
    tbl.push_back('{W_BYTE, 32'h0000_1003, 32'h0,         1'b1, 0, 1'b0, 32'hAABBCCDD, 1'b1, 32'h0000_1000, 4'b1000, 32'h0,         32'h0000_00AA, X_NONE,   2, 1});
    tbl.push_back('{W_HALF, 32'h0000_2002, 32'h1234_ABCD, 1'b0, 2, 1'b0, 32'h0,        1'b1, 32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0,         X_NONE,   4, 3});
    tbl.push_back('{W_HALF, 32'h0000_1002, 32'h0,         1'b1, 1, 1'b0, 32'hAABBCCDD, 1'b1, 32'h0000_1000, 4'b1100, 32'h0,         32'h0000_AABB, X_NONE,   3, 2});
    tbl.push_back('{W_BYTE, 32'h0000_1001, 32'h0,         1'b1, 0, 1'b0, 32'hAABBCCDD, 1'b1, 32'h0000_1000, 4'b0010, 32'h0,         32'h0000_00CC, X_NONE,   2, 1});
    tbl.push_back('{W_WORD, 32'h0000_1004, 32'h0,         1'b1, 2, 1'b0, 32'h11223344, 1'b1, 32'h0000_1004, 4'b1111, 32'h0,         32'h1122_3344, X_NONE,   4, 3});
    tbl.push_back('{W_BYTE, 32'h0000_0011, 32'hFFFF_FF5A, 1'b0, 0, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 4'b0010, 32'h0000_5A00, 32'h0,         X_NONE,   2, 1});
    tbl.push_back('{W_WORD, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1, 1'b0, 32'h0,        1'b1, 32'h0000_0020, 4'b1111, 32'hDEAD_BEEF, 32'h0,         X_NONE,   3, 2});
    tbl.push_back('{W_WORD, 32'h0000_3001, 32'h0,         1'b1, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         X_MIS_LD, 1, 0});
    tbl.push_back('{W_HALF, 32'h0000_2001, 32'h5555,      1'b0, 0, 1'b0, 32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         X_MIS_ST, 1, 0});
    tbl.push_back('{W_WORD, 32'h0000_2002, 32'h5555,      1'b0, 0, 1'b0, 32'h0,        1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         X_MIS_ST, 1, 0});
    tbl.push_back('{W_HALF, 32'h0000_2003, 32'h0,         1'b1, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         X_MIS_LD, 1, 0});
    tbl.push_back('{W_NONE, 32'h0000_1003, 32'h0,         1'b1, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0,         X_NONE,   1, 0});
    tbl.push_back('{W_WORD, 32'h0000_4000, 32'h0BAD_F00D, 1'b0,-1, 1'b0, 32'h0,        1'b1, 32'h0000_4000, 4'b1111, 32'h0BAD_F00D, 32'h0,         X_ST_FLT, 5, 4});
    tbl.push_back('{W_WORD, 32'h0000_4004, 32'h0,         1'b1, 1, 1'b1, 32'h12345678, 1'b1, 32'h0000_4004, 4'b1111, 32'h0,         32'h0,         X_LD_FLT, 3, 2});
    tbl.push_back('{W_BYTE, 32'h0000_4006, 32'h0,         1'b1,-1, 1'b0, 32'h0,        1'b1, 32'h0000_4004, 4'b0100, 32'h0,         32'h0,         X_LD_FLT, 5, 4});
    tbl.push_back('{W_HALF, 32'h0000_4002, 32'h7777,      1'b0, 0, 1'b1, 32'h0,        1'b1, 32'h0000_4000, 4'b1100, 32'h7777_0000, 32'h0,         X_ST_FLT, 2, 1});
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i]);
      run_access(tbl[i], ok_seen, lat, o_data, o_exc, rc, o_addr, o_be, o_wdata, o_write, ok_after);
      e = exp_q.pop_front();
      checks++; if (ok_seen !== 1'b1) begin errors++; $display("FAIL ok_timeout[%0d]: got %0b want 1", i, ok_seen); end
      checks++; if (lat != e.e_lat)   begin errors++; $display("FAIL latency[%0d]: got %0d want %0d", i, lat, e.e_lat); end
      checks++; if (o_data !== e.e_data) begin errors++; $display("FAIL data[%0d]: got %h want %h", i, o_data, e.e_data); end
      checks++; if (o_exc !== e.e_exc)   begin errors++; $display("FAIL exc[%0d]: got %0d want %0d", i, o_exc, e.e_exc); end
      checks++; if (rc != e.e_rc)        begin errors++; $display("FAIL req_cycles[%0d]: got %0d want %0d", i, rc, e.e_rc); end
      checks++; if (ok_after !== 1'b0)   begin errors++; $display("FAIL ok_after_drop[%0d]: got %0b want 0", i, ok_after); end
      if (e.e_req) begin
        checks++; if (o_addr !== e.e_addr) begin errors++; $display("FAIL bus_addr[%0d]: got %h want %h", i, o_addr, e.e_addr); end
        checks++; if (o_be !== e.e_be)     begin errors++; $display("FAIL bus_be[%0d]: got %b want %b", i, o_be, e.e_be); end
        checks++; if (o_write !== !e.rd)   begin errors++; $display("FAIL bus_write[%0d]: got %0b want %0b", i, o_write, !e.rd); end
        if (!e.rd) begin
          checks++; if (o_wdata !== e.e_wdata) begin errors++; $display("FAIL bus_wdata[%0d]: got %h want %h", i, o_wdata, e.e_wdata); end
        end
      end
    end
  endtask

  task automatic test_drain();
    logic ok_any;
    logic ok_seen, ok_after, o_write;
    int lat, rc;
    logic [31:0] o_data, o_addr, o_wdata;
    logic [3:0] o_exc, o_be;
    vec_t v;
    vec_t e;
    ok_any = 1'b0;
    mem_access = 1'b1; mem_addr = 32'h0000_5000; mem_width = W_WORD; mem_is_read = 1'b1;
    bus_ready = 1'b0; bus_error = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 2) mem_access = 1'b0;
      if (c == 5) begin bus_ready = 1'b1; bus_rdata = 32'hCAFE_BABE; end
      else        bus_ready = 1'b0;
      #1;
      ok_any = ok_any | ok;
      if (c == 4) begin
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL drain_req_held: got %0b want 1", bus_req); end
      end
      if (c == 6) begin
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL drain_req_drop: got %0b want 0", bus_req); end
      end
    end
    checks++; if (ok_any !== 1'b0) begin errors++; $display("FAIL drain_ok: got %0b want 0", ok_any); end
    checks++; if (exc !== X_NONE || rdata_out !== 32'd0)
      begin errors++; $display("FAIL drain_idle_out: got %h/%0d want 0/0", rdata_out, exc); end
    v = '{W_HALF, 32'h0000_5002, 32'h0, 1'b1, 0, 1'b0, 32'h8765_4321, 1'b1, 32'h0000_5000, 4'b1100, 32'h0, 32'h0000_8765, X_NONE, 2, 1};
    exp_q.push_back(v);
    run_access(v, ok_seen, lat, o_data, o_exc, rc, o_addr, o_be, o_wdata, o_write, ok_after);
    e = exp_q.pop_front();
    checks++; if (!ok_seen || lat != e.e_lat || o_data !== e.e_data || o_exc !== e.e_exc)
      begin errors++; $display("FAIL after_drain: got ok=%0b lat=%0d data=%h exc=%0d want 1/%0d/%h/%0d", ok_seen, lat, o_data, o_exc, e.e_lat, e.e_data, e.e_exc); end
  endtask

  task automatic test_reset_mid_bus();
    mem_access = 1'b1; mem_addr = 32'h0000_6004; mem_width = W_WORD; mem_is_read = 1'b0; mem_data = 32'h1111_2222;
    @(posedge clk); #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before: got %0b want 1", bus_req); end
    #2; rst = 1'b1; #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %0b want 0", bus_req); end
    checks++; if ({bus_addr, bus_be, bus_wdata, bus_write} !== 69'd0)
      begin errors++; $display("FAIL rstmid_bus: got %h/%b/%h/%b want zeros", bus_addr, bus_be, bus_wdata, bus_write); end
    checks++; if (ok !== 1'b0 || rdata_out !== 32'd0 || exc !== X_NONE)
      begin errors++; $display("FAIL rstmid_out: got %0b/%h/%0d want 0/0/0", ok, rdata_out, exc); end
    mem_access = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic ok_seen, ok_after, o_write;
    int lat, rc;
    logic [31:0] o_data, o_addr, o_wdata;
    logic [3:0] o_exc, o_be;
    vec_t v[2];
    vec_t e;
    v[0] = '{W_BYTE, 32'h0000_7002, 32'h0, 1'b1, 0, 1'b0, 32'h0099_0000, 1'b1, 32'h0000_7000, 4'b0100, 32'h0, 32'h0000_0099, X_NONE, 2, 1};
    v[1] = '{W_WORD, 32'h0000_7008, 32'h0, 1'b1, 0, 1'b0, 32'hFEDC_BA98, 1'b1, 32'h0000_7008, 4'b1111, 32'h0, 32'hFEDC_BA98, X_NONE, 2, 1};
    exp_q.push_back(v[0]);
    exp_q.push_back(v[1]);
    for (int k = 0; k < 2; k++) begin
      run_access(v[k], ok_seen, lat, o_data, o_exc, rc, o_addr, o_be, o_wdata, o_write, ok_after);
      e = exp_q.pop_front();
      checks++; if (!ok_seen || lat != e.e_lat || o_data !== e.e_data || o_exc !== e.e_exc || o_be !== e.e_be)
        begin errors++; $display("FAIL b2b[%0d]: got ok=%0b lat=%0d data=%h exc=%0d be=%b want 1/%0d/%h/%0d/%b", k, ok_seen, lat, o_data, o_exc, o_be, e.e_lat, e.e_data, e.e_exc, e.e_be); end
    end
  endtask

  initial begin
    test_reset();
    test_table_accesses();
    test_drain();
    test_reset_mid_bus();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
